// File: rtl/perf_stats_collector.sv
// Sample statistics (count/min/max/sum/last) for a perf counter, read back through a registered select/read port.
// Define PERF_STATS_HIST_EN to build the optional histogram (bins read at rd_sel 8..8+HIST_BINS-1).
module perf_stats_collector #(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned SUM_WIDTH   = 48,
    parameter int unsigned NSAMP_WIDTH = 16,
    parameter int unsigned HIST_SHIFT  = 4,
    parameter int unsigned HIST_BINS   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_valid,
    input  logic [COUNT_WIDTH-1:0] sample_count,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   rd_req,
    input  logic [3:0]             rd_sel,
    output logic                   rd_valid,
    output logic [SUM_WIDTH-1:0]   rd_data,
    output logic                   stats_valid,
    output logic                   overflow
);

    localparam int unsigned RD_W = (NSAMP_WIDTH > SUM_WIDTH) ? NSAMP_WIDTH : SUM_WIDTH;

    if (HIST_BINS < 2 || HIST_BINS > 8 || HIST_SHIFT >= COUNT_WIDTH || SUM_WIDTH < COUNT_WIDTH) begin : g_bad_params
        $error("perf_stats_collector: illegal parameter combination");
    end

    logic [NSAMP_WIDTH-1:0] n_samples;
    logic [COUNT_WIDTH-1:0] min_val;
    logic [COUNT_WIDTH-1:0] max_val;
    logic [COUNT_WIDTH-1:0] last_val;
    logic [SUM_WIDTH-1:0]   sum_val;
    logic [SUM_WIDTH:0]     sample_ext;
    logic [SUM_WIDTH:0]     sum_next;
    logic                   take;
    logic                   n_full;
    logic                   accept;
    logic [RD_W-1:0]        rd_wide;

    assign n_full     = &n_samples;
    assign take       = sample_valid && enable && !clear;
    assign accept     = take && !n_full;
    assign sample_ext = {{(SUM_WIDTH + 1 - COUNT_WIDTH){1'b0}}, sample_count};
    assign sum_next   = {1'b0, sum_val} + sample_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_samples   <= '0;
            min_val     <= '1;
            max_val     <= '0;
            sum_val     <= '0;
            last_val    <= '0;
            stats_valid <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            n_samples   <= '0;
            min_val     <= '1;
            max_val     <= '0;
            sum_val     <= '0;
            last_val    <= '0;
            stats_valid <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            n_samples   <= n_samples + 1'b1;
            last_val    <= sample_count;
            stats_valid <= 1'b1;
            if (sample_count < min_val) min_val <= sample_count;
            if (sample_count > max_val) max_val <= sample_count;
            if (sum_next[SUM_WIDTH]) begin
                sum_val  <= '1;
                overflow <= 1'b1;
            end else begin
                sum_val  <= sum_next[SUM_WIDTH-1:0];
            end
        end else if (take) begin
            // sample offered while the sample counter is saturated: dropped
            overflow <= 1'b1;
        end
    end

`ifdef PERF_STATS_HIST_EN
    logic [NSAMP_WIDTH-1:0] hist [HIST_BINS];
    logic [COUNT_WIDTH-1:0] bin_raw;
    logic [2:0]             bin_idx;

    assign bin_raw = sample_count >> HIST_SHIFT;
    assign bin_idx = (bin_raw >= COUNT_WIDTH'(HIST_BINS - 1)) ? 3'(HIST_BINS - 1) : bin_raw[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < HIST_BINS; i++) hist[i] <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < HIST_BINS; i++) hist[i] <= '0;
        end else if (accept && !(&hist[bin_idx])) begin
            hist[bin_idx] <= hist[bin_idx] + 1'b1;
        end
    end
`endif

    always_comb begin
        rd_wide = '0;
        case (rd_sel)
            4'd0: rd_wide[NSAMP_WIDTH-1:0] = n_samples;
            4'd1: rd_wide[COUNT_WIDTH-1:0] = min_val;
            4'd2: rd_wide[COUNT_WIDTH-1:0] = max_val;
            4'd3: rd_wide[SUM_WIDTH-1:0]   = sum_val;
            4'd4: rd_wide[COUNT_WIDTH-1:0] = last_val;
            4'd5: rd_wide[1:0]             = {overflow, stats_valid};
            default: begin
`ifdef PERF_STATS_HIST_EN
                if (rd_sel[3] && (32'(rd_sel[2:0]) < HIST_BINS))
                    rd_wide[NSAMP_WIDTH-1:0] = hist[rd_sel[2:0]];
`endif
            end
        endcase
    end

    // Read data is captured from pre-update state, so a same-edge accept is not visible yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rd_data <= rd_wide[SUM_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_perf_stats_collector.sv
// Directed bench: default instance plus an 8-bit sum instance and a 2-bit sample-counter instance.
module tb_perf_stats_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [31:0] sample_count;
    logic        enable;
    logic        clear;
    logic        rd_req;
    logic [3:0]  rd_sel;

    logic        a_rd_valid, a_stats_valid, a_overflow;
    logic [47:0] a_rd_data;
    logic        s_rd_valid, s_stats_valid, s_overflow;
    logic [7:0]  s_rd_data;
    logic        c_rd_valid, c_stats_valid, c_overflow;
    logic [47:0] c_rd_data;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    perf_stats_collector u_dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_count(sample_count),
        .enable(enable), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .stats_valid(a_stats_valid), .overflow(a_overflow)
    );

    perf_stats_collector #(.COUNT_WIDTH(8), .SUM_WIDTH(8), .NSAMP_WIDTH(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_count(sample_count[7:0]),
        .enable(enable), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(s_rd_valid), .rd_data(s_rd_data), .stats_valid(s_stats_valid), .overflow(s_overflow)
    );

    perf_stats_collector #(.NSAMP_WIDTH(2)) u_cnt (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_count(sample_count),
        .enable(enable), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(c_rd_valid), .rd_data(c_rd_data), .stats_valid(c_stats_valid), .overflow(c_overflow)
    );

    task automatic send(input logic [31:0] v);
        sample_valid = 1'b1;
        sample_count = v;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] s);
        rd_req = 1'b1;
        rd_sel = s;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (a_rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b expected 0", a_rd_valid); else passed++;
        total++; if (a_rd_data !== 48'd0) $display("FAIL reset_rd_data: got %0h expected 0", a_rd_data); else passed++;
        total++; if (a_stats_valid !== 1'b0 || a_overflow !== 1'b0)
            $display("FAIL reset_flags: got sv=%0b ov=%0b expected 0 0", a_stats_valid, a_overflow); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(4'd1);
        total++; if (a_rd_data !== 48'h0000_FFFF_FFFF) $display("FAIL reset_min: got %0h expected ffffffff", a_rd_data); else passed++;
        rd(4'd0);
        total++; if (a_rd_data !== 48'd0) $display("FAIL reset_n: got %0d expected 0", a_rd_data); else passed++;
    endtask

    task automatic test_accumulate();
        logic [47:0] exp_tab [6];
        exp_tab = '{48'd3, 48'd3, 48'd25, 48'd38, 48'd25, 48'd1};
        send(32'd10);
        send(32'd3);
        send(32'd25);
        total++; if (a_stats_valid !== 1'b1) $display("FAIL acc_stats_valid: got %0b expected 1", a_stats_valid); else passed++;
        for (int i = 0; i < 6; i++) begin
            rd(4'(i));
            total++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp_tab[i])
                $display("FAIL acc_sel%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, a_rd_valid, a_rd_data, exp_tab[i]);
            else passed++;
        end
        rd(4'd6);
        total++; if (a_rd_data !== 48'd0) $display("FAIL acc_sel6: got %0d expected 0", a_rd_data); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sel_tab [3];
        logic [47:0] exp_tab [3];
        rd_req       = 1'b1;
        rd_sel       = 4'd3;
        sample_valid = 1'b1;
        sample_count = 32'd7;
        @(negedge clk);
        rd_req       = 1'b0;
        sample_valid = 1'b0;
        total++; if (a_rd_valid !== 1'b1 || a_rd_data !== 48'd38)
            $display("FAIL collide_read: got valid=%0b data=%0d expected valid=1 data=38", a_rd_valid, a_rd_data); else passed++;
        @(negedge clk);
        total++; if (a_rd_valid !== 1'b0 || a_rd_data !== 48'd38)
            $display("FAIL collide_pulse_hold: got valid=%0b data=%0d expected valid=0 data=38", a_rd_valid, a_rd_data); else passed++;
        rd(4'd3);
        total++; if (a_rd_data !== 48'd45) $display("FAIL collide_followup: got %0d expected 45", a_rd_data); else passed++;

        sel_tab = '{4'd0, 4'd2, 4'd4};
        exp_tab = '{48'd4, 48'd25, 48'd7};
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_sel = sel_tab[i];
            @(negedge clk);
            total++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp_tab[i])
                $display("FAIL b2b_%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, a_rd_valid, a_rd_data, exp_tab[i]);
            else passed++;
        end
        rd_req = 1'b0;
        @(negedge clk);
        total++; if (a_rd_valid !== 1'b0 || a_rd_data !== 48'd7)
            $display("FAIL b2b_end: got valid=%0b data=%0d expected valid=0 data=7", a_rd_valid, a_rd_data); else passed++;
    endtask

    task automatic test_clear();
        logic [47:0] exp_tab [6];
        exp_tab = '{48'd0, 48'h0000_FFFF_FFFF, 48'd0, 48'd0, 48'd0, 48'd0};
        clear        = 1'b1;
        sample_valid = 1'b1;
        sample_count = 32'd99;
        @(negedge clk);
        clear        = 1'b0;
        sample_valid = 1'b0;
        total++; if (a_stats_valid !== 1'b0 || a_overflow !== 1'b0)
            $display("FAIL clear_flags: got sv=%0b ov=%0b expected 0 0", a_stats_valid, a_overflow); else passed++;
        total++; if (a_rd_data !== 48'd7) $display("FAIL clear_rd_data_kept: got %0d expected 7", a_rd_data); else passed++;
        for (int i = 0; i < 6; i++) begin
            rd(4'(i));
            total++;
            if (a_rd_data !== exp_tab[i])
                $display("FAIL clear_sel%0d: got %0h expected %0h", i, a_rd_data, exp_tab[i]);
            else passed++;
        end
        enable = 1'b0;
        send(32'd50);
        enable = 1'b1;
        rd(4'd0);
        total++; if (a_rd_data !== 48'd0 || a_stats_valid !== 1'b0)
            $display("FAIL disabled_sample: got n=%0d sv=%0b expected n=0 sv=0", a_rd_data, a_stats_valid); else passed++;
    endtask

    task automatic test_sum_saturation();
        do_clear();
        send(32'd200);
        send(32'd100);
        total++; if (s_overflow !== 1'b1) $display("FAIL sat_overflow: got %0b expected 1", s_overflow); else passed++;
        rd(4'd3);
        total++; if (s_rd_data !== 8'd255) $display("FAIL sat_sum: got %0d expected 255", s_rd_data); else passed++;
        rd(4'd0);
        total++; if (s_rd_data !== 8'd2) $display("FAIL sat_n: got %0d expected 2", s_rd_data); else passed++;
        rd(4'd2);
        total++; if (s_rd_data !== 8'd200) $display("FAIL sat_max: got %0d expected 200", s_rd_data); else passed++;
        rd(4'd4);
        total++; if (s_rd_data !== 8'd100) $display("FAIL sat_last: got %0d expected 100", s_rd_data); else passed++;
    endtask

    task automatic test_count_saturation();
        do_clear();
        for (int i = 1; i <= 5; i++) send(32'(i));
        total++; if (c_overflow !== 1'b1) $display("FAIL cnt_overflow: got %0b expected 1", c_overflow); else passed++;
        rd(4'd0);
        total++; if (c_rd_data !== 48'd3) $display("FAIL cnt_n: got %0d expected 3", c_rd_data); else passed++;
        rd(4'd4);
        total++; if (c_rd_data !== 48'd3) $display("FAIL cnt_last: got %0d expected 3", c_rd_data); else passed++;
        rd(4'd3);
        total++; if (c_rd_data !== 48'd6) $display("FAIL cnt_sum: got %0d expected 6", c_rd_data); else passed++;

        do_clear();
        total++; if (c_overflow !== 1'b0) $display("FAIL cnt_clear_ov: got %0b expected 0", c_overflow); else passed++;
        for (int i = 1; i <= 3; i++) send(32'(i));
        enable = 1'b0;
        send(32'd9);
        enable = 1'b1;
        total++; if (c_overflow !== 1'b0) $display("FAIL cnt_disabled_ov: got %0b expected 0", c_overflow); else passed++;
        send(32'd9);
        total++; if (c_overflow !== 1'b1) $display("FAIL cnt_full_ov: got %0b expected 1", c_overflow); else passed++;
        rd(4'd4);
        total++; if (c_rd_data !== 48'd3) $display("FAIL cnt_full_last: got %0d expected 3", c_rd_data); else passed++;
    endtask

    task automatic test_hist();
        do_clear();
        send(32'd5);
        send(32'd20);
        send(32'd500);
        rd(4'd5);
        total++; if (a_rd_data !== 48'd1) $display("FAIL hist_flags: got %0d expected 1", a_rd_data); else passed++;
`ifdef PERF_STATS_HIST_EN
        rd(4'd8);
        total++; if (a_rd_data !== 48'd1) $display("FAIL hist_bin0: got %0d expected 1", a_rd_data); else passed++;
        rd(4'd9);
        total++; if (a_rd_data !== 48'd1) $display("FAIL hist_bin1: got %0d expected 1", a_rd_data); else passed++;
        rd(4'd15);
        total++; if (a_rd_data !== 48'd1) $display("FAIL hist_bin7: got %0d expected 1", a_rd_data); else passed++;
        rd(4'd10);
        total++; if (a_rd_data !== 48'd0) $display("FAIL hist_bin2: got %0d expected 0", a_rd_data); else passed++;
`else
        rd(4'd8);
        total++; if (a_rd_data !== 48'd0) $display("FAIL nohist_sel8: got %0d expected 0", a_rd_data); else passed++;
        rd(4'd15);
        total++; if (a_rd_data !== 48'd0) $display("FAIL nohist_sel15: got %0d expected 0", a_rd_data); else passed++;
`endif
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_count = '0;
        enable       = 1'b1;
        clear        = 1'b0;
        rd_req       = 1'b0;
        rd_sel       = '0;
        test_reset();
        test_accumulate();
        test_back_to_back();
        test_clear();
        test_sum_saturation();
        test_count_saturation();
        test_hist();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
